// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the combinational instruction
// memory address and fills the IF/ID slot under a valid/ready handshake.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned PC_STEP      = 1,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam state_t RESET_STATE = START_HALTED ? HALT : RUN;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   opc_q, opc_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic              slot_free_c;
  logic              fetch_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: redirect > halt > resume > fetch
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    opc_d       = opc_q;
    cnt_d       = cnt_q;
    slot_free_c = !valid_q || out_ready;
    fetch_c     = (state_q == RUN) && slot_free_c && !redirect_valid && !halt_req;

    if (halt_req) begin
      state_d = HALT;
    end else if (!redirect_valid && resume && (state_q == HALT)) begin
      state_d = RUN;
    end

    if (redirect_valid) begin
      // Flush: the slot is dropped even if decode was accepting it
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (fetch_c) begin
      instr_d = imem_data;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + XLEN'(PC_STEP);
      cnt_d   = cnt_q + XLEN'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule
